rx_comma_aligner: RTL and testbench

// RX symbol aligner between the CDR/deserializer and the 8b/10b decoder. It takes unaligned 10-bit words

---
 rtl/rx_comma_aligner.sv | 173 +++++++++++++++++
 tb/tb_rx_comma_aligner.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_comma_aligner.sv
// K28.5 comma aligner between the deserializer and the 8b/10b decoder.
// Finds the comma bit offset, locks after repeated hits, and emits symbol-aligned words.
module rx_comma_aligner #(
  parameter int                    DATA_WIDTH = 10,
  parameter logic [DATA_WIDTH-1:0] COMMA_N    = 10'b0011111010,
  parameter logic [DATA_WIDTH-1:0] COMMA_P    = 10'b1100000101,
  parameter int                    LOCK_COUNT = 3,
  parameter int                    LOSS_COUNT = 4
) (
  input  logic                  Word_CLK,
  input  logic                  Reset,
  input  logic [DATA_WIDTH-1:0] Data_in,
  input  logic                  Data_in_valid,
  input  logic                  RxPolarity,
  output logic [DATA_WIDTH-1:0] Data_out,
  output logic                  Data_out_valid,
  output logic                  Comma_Detected,
  output logic                  Aligned,
  output logic [3:0]            Align_Offset
);

  localparam int CNT_MAX = (LOCK_COUNT > LOSS_COUNT) ? LOCK_COUNT : LOSS_COUNT;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] LOCK_C = CW'(LOCK_COUNT);
  localparam logic [CW-1:0] LOSS_C = CW'(LOSS_COUNT);
  localparam logic [CW-1:0] ONE_C  = CW'(1);

  typedef enum logic [1:0] {
    UNALIGNED = 2'd0,
    ALIGNING  = 2'd1,
    LOCKED    = 2'd2
  } state_t;

  function automatic logic is_comma(input logic [DATA_WIDTH-1:0] s);
    return (s == COMMA_N) || (s == COMMA_P);
  endfunction

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == {CW{1'b1}}) ? v : v + ONE_C;
  endfunction

  logic [DATA_WIDTH-1:0]   word_p0, word_p1;
  logic [1:0]              seen;
  logic                    advance, win_ok;
  logic [2*DATA_WIDTH-1:0] win;
  logic [15:0]             hit;
  logic                    any_hit;
  logic [3:0]              first_hit;
  logic [DATA_WIDTH-1:0]   out_slice;
  state_t                  state, state_nxt;
  logic [3:0]              cand, cand_nxt, offs, offs_nxt;
  logic [CW-1:0]           cnt, cnt_nxt, miss, miss_nxt;
  logic [DATA_WIDTH-1:0]   data_p2;
  logic                    vld_p2, comma_p2;

  assign advance = Data_in_valid;
  assign win_ok  = advance && (seen == 2'd2);
  assign win     = {word_p1, word_p0};

  // Stage p0/p1: polarity-corrected word history forming the 20-bit search window
  always_ff @(posedge Word_CLK or posedge Reset) begin
    if (Reset) begin
      word_p0 <= '0;
      word_p1 <= '0;
      seen    <= 2'd0;
    end else if (advance) begin
      word_p1 <= word_p0;
      word_p0 <= Data_in ^ {DATA_WIDTH{RxPolarity}};
      if (seen != 2'd2) seen <= seen + 2'd1;
    end
  end

  // Descending scan so the lowest hitting offset is the one left in first_hit
  always_comb begin
    hit       = '0;
    any_hit   = 1'b0;
    first_hit = '0;
    out_slice = '0;
    for (int k = DATA_WIDTH - 1; k >= 0; k--) begin
      hit[k] = is_comma(win[2*DATA_WIDTH-1-k -: DATA_WIDTH]);
      if (offs == 4'(k)) out_slice = win[2*DATA_WIDTH-1-k -: DATA_WIDTH];
      if (hit[k]) begin
        any_hit   = 1'b1;
        first_hit = 4'(k);
      end
    end
  end

  always_ff @(posedge Word_CLK or posedge Reset) begin
    if (Reset) begin
      state <= UNALIGNED;
      cand  <= '0;
      cnt   <= '0;
      offs  <= '0;
      miss  <= '0;
    end else if (advance) begin
      state <= state_nxt;
      cand  <= cand_nxt;
      cnt   <= cnt_nxt;
      offs  <= offs_nxt;
      miss  <= miss_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cand_nxt  = cand;
    cnt_nxt   = cnt;
    offs_nxt  = offs;
    miss_nxt  = miss;
    if (win_ok && any_hit) begin
      case (state)
        UNALIGNED: begin
          cand_nxt = first_hit;
          cnt_nxt  = ONE_C;
          if (LOCK_COUNT == 1) begin
            state_nxt = LOCKED;
            offs_nxt  = first_hit;
            miss_nxt  = '0;
          end else begin
            state_nxt = ALIGNING;
          end
        end
        ALIGNING: begin
          if (hit[cand]) begin
            cnt_nxt = sat_inc(cnt);
            if (cnt_nxt >= LOCK_C) begin
              state_nxt = LOCKED;
              offs_nxt  = cand;
              miss_nxt  = '0;
            end
          end else begin
            cand_nxt = first_hit;
            cnt_nxt  = ONE_C;
          end
        end
        LOCKED: begin
          // A lock-dropping window leaves cand alone; the next hit reseeds it
          if (hit[offs]) begin
            miss_nxt = '0;
          end else begin
            miss_nxt = sat_inc(miss);
            if (miss_nxt >= LOSS_C) state_nxt = UNALIGNED;
          end
        end
        default: state_nxt = UNALIGNED;
      endcase
    end
  end

  always_comb begin
    Aligned = (state == LOCKED);
  end

  // Stage p2: aligned symbol register toward the decoder
  always_ff @(posedge Word_CLK or posedge Reset) begin
    if (Reset) begin
      data_p2  <= '0;
      vld_p2   <= 1'b0;
      comma_p2 <= 1'b0;
    end else begin
      vld_p2   <= advance && Aligned;
      comma_p2 <= advance && Aligned && hit[offs];
      if (advance && Aligned) data_p2 <= out_slice;
    end
  end

  assign Data_out       = data_p2;
  assign Data_out_valid = vld_p2;
  assign Comma_Detected = comma_p2;
  assign Align_Offset   = offs;

endmodule

// File: tb/tb_rx_comma_aligner.sv
// Bench for rx_comma_aligner: vector table, directed multi-cycle sequences and a
// randomized bit stream compared against a queue-based behavioural model.
module tb_rx_comma_aligner;

  localparam logic [9:0] CN    = 10'b0011111010;
  localparam logic [9:0] CP    = 10'b1100000101;
  localparam int         LOCKN = 3;
  localparam int         LOSSN = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [9:0] din = '0;
  logic       dv  = 1'b0;
  logic       pol = 1'b0;
  logic [9:0] dout;
  logic       dov, cdet, algn;
  logic [3:0] aoff;

  rx_comma_aligner #(
    .DATA_WIDTH(10), .COMMA_N(CN), .COMMA_P(CP),
    .LOCK_COUNT(LOCKN), .LOSS_COUNT(LOSSN)
  ) dut (
    .Word_CLK(clk), .Reset(rst), .Data_in(din), .Data_in_valid(dv),
    .RxPolarity(pol), .Data_out(dout), .Data_out_valid(dov),
    .Comma_Detected(cdet), .Aligned(algn), .Align_Offset(aoff)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // behavioural model: last two accepted words plus the alignment rules
  logic [9:0] hist[$];
  int         m_mode;   // 0 unaligned, 1 aligning, 2 locked
  int         m_cand, m_cnt, m_off, m_miss;
  logic [9:0] m_data;
  bit         m_vld, m_comma;

  bit bq[$];

  typedef struct {
    logic [9:0] din;
    logic       exp_al;
    logic [3:0] exp_off;
    logic       exp_vld;
    logic       exp_cd;
    logic [9:0] exp_do;
  } vec_t;
  vec_t tv[12];

  function automatic bit is_k(logic [9:0] s);
    return (s == CN) || (s == CP);
  endfunction

  function automatic void model_reset();
    hist.delete();
    m_mode = 0; m_cand = 0; m_cnt = 0; m_off = 0; m_miss = 0;
    m_data = '0; m_vld = 0; m_comma = 0;
  endfunction

  function automatic void model_edge(bit v, logic [9:0] d, bit p);
    logic [19:0] w;
    logic [9:0]  sl[10];
    bit          h[10];
    int          first;
    m_vld   = 0;
    m_comma = 0;
    if (!v) return;
    if (hist.size() >= 2) begin
      w     = {hist[0], hist[1]};
      first = -1;
      for (int k = 0; k < 10; k++) begin
        sl[k] = 10'((w >> (10 - k)) & 20'h003FF);
        h[k]  = is_k(sl[k]);
        if (h[k] && first < 0) first = k;
      end
      if (m_mode == 2) begin
        m_vld   = 1;
        m_data  = sl[m_off];
        m_comma = h[m_off];
      end
      if (first >= 0) begin
        case (m_mode)
          0: begin
            m_cand = first; m_cnt = 1;
            if (LOCKN == 1) begin m_mode = 2; m_off = first; m_miss = 0; end
            else m_mode = 1;
          end
          1: begin
            if (h[m_cand]) begin
              m_cnt++;
              if (m_cnt >= LOCKN) begin m_mode = 2; m_off = m_cand; m_miss = 0; end
            end else begin
              m_cand = first; m_cnt = 1;
            end
          end
          default: begin
            if (h[m_off]) m_miss = 0;
            else begin
              m_miss++;
              if (m_miss >= LOSSN) m_mode = 0;
            end
          end
        endcase
      end
    end
    hist.push_back(d ^ {10{p}});
    if (hist.size() > 2) void'(hist.pop_front());
  endfunction

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, want, $time);
    end
  endtask

  task automatic compare_model(input string tag);
    check({tag, ".valid"},   32'(dov),  32'(m_vld));
    check({tag, ".comma"},   32'(cdet), 32'(m_comma));
    check({tag, ".aligned"}, 32'(algn), 32'(m_mode == 2));
    check({tag, ".offset"},  32'(aoff), 32'(m_off));
    check({tag, ".data"},    32'(dout), 32'(m_data));
  endtask

  task automatic cycle(input bit v, input logic [9:0] d, input bit chk);
    dv  = v;
    din = d;
    @(posedge clk);
    model_edge(v, d, pol);
    #1;
    if (chk) compare_model("model");
  endtask

  task automatic do_reset();
    dv  = 1'b0;
    rst = 1'b1;
    model_reset();
    bq.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  function automatic void push_sym(logic [9:0] s);
    for (int i = 9; i >= 0; i--) bq.push_back(s[i]);
  endfunction

  function automatic void push_bits(int n, logic [9:0] v);
    for (int i = n - 1; i >= 0; i--) bq.push_back(v[i]);
  endfunction

  function automatic logic [9:0] pop_word();
    logic [9:0] w;
    for (int i = 9; i >= 0; i--) w[i] = bq.pop_front();
    return w;
  endfunction

  task automatic drain();
    while (bq.size() >= 10) cycle(1'b1, pop_word(), 1'b1);
  endtask

  // n commas at the current bit position, each followed by a zero symbol
  task automatic commas(input int n);
    for (int i = 0; i < n; i++) begin
      push_sym(CN);
      push_sym(10'h000);
    end
    push_sym(10'h000);
    push_sym(10'h000);
    drain();
  endtask

  function automatic vec_t mk(logic [9:0] d, logic al, logic [3:0] off, logic vl, logic cd, logic [9:0] dq);
    vec_t r;
    r.din = d; r.exp_al = al; r.exp_off = off; r.exp_vld = vl; r.exp_cd = cd; r.exp_do = dq;
    return r;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] held;
    int drops, seen_k, seen_inv;

    // aligned stream: commas at offset 0 on every other word
    tv[0]  = mk(CN,      0, 0, 0, 0, 10'h000);
    tv[1]  = mk(10'h000, 0, 0, 0, 0, 10'h000);
    tv[2]  = mk(CN,      0, 0, 0, 0, 10'h000);
    tv[3]  = mk(10'h000, 0, 0, 0, 0, 10'h000);
    tv[4]  = mk(CN,      0, 0, 0, 0, 10'h000);
    tv[5]  = mk(10'h000, 0, 0, 0, 0, 10'h000);
    tv[6]  = mk(CN,      1, 0, 0, 0, 10'h000);
    tv[7]  = mk(10'h155, 1, 0, 1, 0, 10'h000);
    tv[8]  = mk(10'h2AA, 1, 0, 1, 1, CN);
    tv[9]  = mk(10'h3C3, 1, 0, 1, 0, 10'h155);
    tv[10] = mk(10'h000, 1, 0, 1, 0, 10'h2AA);
    tv[11] = mk(10'h000, 1, 0, 1, 0, 10'h3C3);

    // reset state
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset.data",    32'(dout), 32'h0);
    check("reset.valid",   32'(dov),  32'h0);
    check("reset.comma",   32'(cdet), 32'h0);
    check("reset.aligned", 32'(algn), 32'h0);
    check("reset.offset",  32'(aoff), 32'h0);
    rst = 1'b0;

    // three back-to-back commas at offset 3, then a later comma to observe latency
    do_reset();
    push_bits(3, 10'h000);
    repeat (3) push_sym(CN);
    repeat (2) push_sym(10'h000);
    push_sym(CN);
    repeat (3) push_sym(10'h000);
    for (int i = 1; i <= 10; i++) begin
      cycle(1'b1, pop_word(), 1'b1);
      case (i)
        4: check("t1.pre_lock", 32'(algn), 32'h0);
        5: begin
          check("t1.lock_aligned", 32'(algn), 32'h1);
          check("t1.lock_offset",  32'(aoff), 32'h3);
        end
        6: begin
          check("t1.first_valid", 32'(dov),  32'h1);
          check("t1.first_data",  32'(dout), 32'h0);
        end
        8: begin
          check("t1.comma_data", 32'(dout), 32'(CN));
          check("t1.comma_flag", 32'(cdet), 32'h1);
        end
        default: ;
      endcase
    end

    // table: aligned stream
    do_reset();
    for (int i = 0; i < 12; i++) begin
      cycle(1'b1, tv[i].din, 1'b0);
      check($sformatf("tbl%0d.aligned", i), 32'(algn), 32'(tv[i].exp_al));
      check($sformatf("tbl%0d.offset", i),  32'(aoff), 32'(tv[i].exp_off));
      check($sformatf("tbl%0d.valid", i),   32'(dov),  32'(tv[i].exp_vld));
      check($sformatf("tbl%0d.comma", i),   32'(cdet), 32'(tv[i].exp_cd));
      check($sformatf("tbl%0d.data", i),    32'(dout), 32'(tv[i].exp_do));
    end

    // stall while locked
    held = dout;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 10'($urandom), 1'b1);
      check("stall.valid", 32'(dov),  32'h0);
      check("stall.held",  32'(dout), 32'(held));
    end
    cycle(1'b1, 10'h11A, 1'b1);
    cycle(1'b1, 10'h22B, 1'b1);
    cycle(1'b1, 10'h33C, 1'b1);
    check("resume.data",    32'(dout), 32'h11A);
    check("resume.aligned", 32'(algn), 32'h1);

    // polarity toggle while locked
    pol = 1'b1;
    drops = 0; seen_k = 0; seen_inv = 0;
    for (int i = 0; i < 12; i++) begin
      cycle(1'b1, (i % 2 == 0) ? CN : 10'h000, 1'b1);
      if (!algn) drops++;
      if (dov && cdet) seen_k++;
      if (dov && dout == 10'h3FF) seen_inv++;
    end
    check("pol.drops",     32'(drops),        32'h0);
    check("pol.commas",    32'(seen_k > 0),   32'h1);
    check("pol.inverted",  32'(seen_inv > 0), 32'h1);

    // asynchronous reset between edges
    dv = 1'b0;
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("async.data",    32'(dout), 32'h0);
    check("async.valid",   32'(dov),  32'h0);
    check("async.comma",   32'(cdet), 32'h0);
    check("async.aligned", 32'(algn), 32'h0);
    check("async.offset",  32'(aoff), 32'h0);
    pol = 1'b0;
    do_reset();

    // lock at 3, loss to commas at 7, re-lock at 7
    push_bits(3, 10'h000);
    commas(3);
    check("t3.lock3_aligned", 32'(algn), 32'h1);
    check("t3.lock3_offset",  32'(aoff), 32'h3);
    push_bits(4, 10'h000);
    commas(3);
    check("t3.three_miss", 32'(algn), 32'h1);
    commas(1);
    check("t3.lost",      32'(algn), 32'h0);
    check("t3.held_off",  32'(aoff), 32'h3);
    commas(2);
    check("t3.relock_pending", 32'(algn), 32'h0);
    commas(1);
    check("t3.relock_aligned", 32'(algn), 32'h1);
    check("t3.relock_offset",  32'(aoff), 32'h7);

    // candidate switch from 3 to 5
    do_reset();
    push_bits(3, 10'h000);
    commas(2);
    check("t4.two_at3", 32'(algn), 32'h0);
    push_bits(2, 10'h000);
    commas(1);
    check("t4.one_at5", 32'(algn), 32'h0);
    commas(1);
    check("t4.two_at5", 32'(algn), 32'h0);
    commas(1);
    check("t4.lock_aligned", 32'(algn), 32'h1);
    check("t4.lock_offset",  32'(aoff), 32'h5);

    // randomized bit stream against the model
    do_reset();
    for (int it = 0; it < 600; it++) begin
      int r;
      if (it == 300) do_reset();
      r = $urandom_range(0, 15);
      if (r < 5) push_sym(($urandom_range(0, 1) == 0) ? CN : CP);
      else if (r == 5) push_bits($urandom_range(1, 9), 10'($urandom));
      else push_sym(10'($urandom));
      if ($urandom_range(0, 99) == 0) pol = ~pol;
      while (bq.size() >= 10) begin
        if ($urandom_range(0, 7) == 0) cycle(1'b0, 10'($urandom), 1'b1);
        cycle(1'b1, pop_word(), 1'b1);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
